// File: rtl/rca_4bit_adder.sv
// 4-bit ripple-carry adder with combinational sum/carry/overflow and a
// registered copy of the result for pipelined consumers.

// One full-adder stage of the ripple chain.
module rca_full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   logic p;

   assign p     = a ^ b;
   assign s     = p ^ c_in;
   assign c_out = (a & b) | (c_in & p);

endmodule

module rca_4bit_adder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       ovf,
   output logic [3:0] s_q,
   output logic       cout_q,
   output logic       ovf_q
);

   // c[i] is the carry into stage i; c[4] leaves the top stage.
   logic [4:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_stage
      rca_full_adder u_fa (
         .a     (a[i]),
         .b     (b[i]),
         .c_in  (c[i]),
         .s     (s[i]),
         .c_out (c[i+1])
      );
   end

   assign cout = c[4];
   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign ovf  = c[3] ^ c[4];

   // Capture the settled combinational result; async clear on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= 4'b0000;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         s_q    <= s;
         cout_q <= cout;
         ovf_q  <= ovf;
      end
   end

endmodule

// File: tb/tb_rca_4bit_adder.sv
// Self-checking bench for rca_4bit_adder: directed table, exhaustive sweep,
// random vectors, registered path and asynchronous reset sequences.
`timescale 1ns/1ps

module tb_rca_4bit_adder;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [3:0] s;
   logic       cout;
   logic       ovf;
   logic [3:0] s_q;
   logic       cout_q;
   logic       ovf_q;

   int total;
   int bad;

   typedef struct {
      string      name;
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] s;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs[8];

   rca_4bit_adder dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .s      (s),
      .cout   (cout),
      .ovf    (ovf),
      .s_q    (s_q),
      .cout_q (cout_q),
      .ovf_q  (ovf_q)
   );

   // Free-running clock, period 20; rising edges at 10, 30, 50, ...
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (a=%0d b=%0d cin=%0d)", name, act, exp, a, b, cin);
      end
   endtask

   // Drive inputs just after a falling edge, then let them settle.
   task automatic apply(input logic [3:0] ai, input logic [3:0] bi, input logic ci);
      @(negedge clk);
      a   = ai;
      b   = bi;
      cin = ci;
      #5;
   endtask

   // Behavioural reference: 5-bit sum and signed overflow from operand signs.
   task automatic check_model(input string name);
      logic [4:0] sum;
      logic       exp_ovf;
      sum     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      exp_ovf = (a[3] == b[3]) && (sum[3] != a[3]);
      check(name, {3'b000, cout, s}, {3'b000, sum});
      check({name, "_ovf"}, {7'd0, ovf}, {7'd0, exp_ovf});
   endtask

   initial begin
      total = 0;
      bad   = 0;

      vecs[0] = '{"zero",      4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[1] = '{"cin_only",  4'd0,  4'd0,  1'b1, 4'b0001, 1'b0, 1'b0};
      vecs[2] = '{"ripple",    4'd15, 4'd1,  1'b0, 4'b0000, 1'b1, 1'b0};
      vecs[3] = '{"max",       4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0};
      vecs[4] = '{"pos_ovf",   4'd7,  4'd1,  1'b0, 4'b1000, 1'b0, 1'b1};
      vecs[5] = '{"neg_ovf",   4'd8,  4'd8,  1'b0, 4'b0000, 1'b1, 1'b1};
      vecs[6] = '{"carry16",   4'd5,  4'd10, 1'b1, 4'b0000, 1'b1, 1'b0};
      vecs[7] = '{"six_three", 4'd6,  4'd3,  1'b0, 4'b1001, 1'b0, 1'b1};

      rst_n = 1'b0;
      a     = 4'd0;
      b     = 4'd0;
      cin   = 1'b0;
      #2;
      check("reset_s_q",    {4'd0, s_q},    8'd0);
      check("reset_cout_q", {7'd0, cout_q}, 8'd0);
      check("reset_ovf_q",  {7'd0, ovf_q},  8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].cin);
         check({vecs[i].name, "_s"},    {4'd0, s},    {4'd0, vecs[i].s});
         check({vecs[i].name, "_cout"}, {7'd0, cout}, {7'd0, vecs[i].cout});
         check({vecs[i].name, "_ovf"},  {7'd0, ovf},  {7'd0, vecs[i].ovf});
      end

      for (int v = 0; v < 512; v++) begin
         apply(v[3:0], v[7:4], v[8]);
         check_model("sweep");
      end

      for (int r = 0; r < 80; r++) begin
         apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         check_model("random");
      end

      // Registered path: previous value holds until the capturing edge.
      apply(4'd3, 4'd2, 1'b0);
      @(posedge clk);
      #1;
      check("reg_prior", {4'd0, s_q}, 8'b0000_0101);
      apply(4'd9, 4'd4, 1'b1);
      check("reg_hold", {4'd0, s_q}, 8'b0000_0101);
      check("comb_9_4_1", {3'd0, cout, s}, 8'b0000_1110);
      @(posedge clk);
      #1;
      check("reg_s_q",    {4'd0, s_q},    8'b0000_1110);
      check("reg_cout_q", {7'd0, cout_q}, 8'd0);
      check("reg_ovf_q",  {7'd0, ovf_q},  8'd0);

      // Load a fully nonzero registered state: 8+9 = 17, signed overflow.
      apply(4'd8, 4'd9, 1'b0);
      @(posedge clk);
      #1;
      check("load_s_q",    {4'd0, s_q},    8'b0000_0001);
      check("load_cout_q", {7'd0, cout_q}, 8'd1);
      check("load_ovf_q",  {7'd0, ovf_q},  8'd1);

      // Asynchronous reset between edges clears registers immediately.
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_s_q",    {4'd0, s_q},    8'd0);
      check("async_cout_q", {7'd0, cout_q}, 8'd0);
      check("async_ovf_q",  {7'd0, ovf_q},  8'd0);
      check("async_comb",   {3'd0, cout, s}, 8'b0001_0001);
      a = 4'd5;
      b = 4'd6;
      #5;
      check("rst_comb_track", {3'd0, cout, s}, 8'b0000_1011);
      @(posedge clk);
      #1;
      check("rst_hold_s_q",    {4'd0, s_q},    8'd0);
      check("rst_hold_cout_q", {7'd0, cout_q}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #5;
      check("release_pre_edge", {4'd0, s_q}, 8'd0);
      @(posedge clk);
      #1;
      check("release_reload", {4'd0, s_q}, 8'b0000_1011);
      check("release_cout_q", {7'd0, cout_q}, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
